// File: rtl/gf2m_sqrt_iter.sv
// gf2m_sqrt_iter: multi-cycle square root in GF(2^M), polynomial basis.
// sqrt(a) = a^(2^(M-1)); the engine applies M-1 squarings, SQ_PER per clock,
// each squaring being a bit-spread followed by reduction mod x^M + P(x).
module gf2m_sqrt_iter #(
  parameter int          M      = 163,
  parameter logic [M-1:0] P     = 'hC9,
  parameter int          SQ_PER = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] a_in,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] root
);

  // Number of clocks spent in RUN and the counter width that can hold it.
  localparam int N  = (M - 1) / SQ_PER;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [M-1:0]   acc;
  logic [M-1:0]   acc_next;
  logic [M-1:0]   acc_sq;
  logic [M-1:0]   root_next;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_next;
  logic           done_next;

  // One field squaring: spread bit i to bit 2i, then fold the high half back
  // down with x^M = P(x). deg(P) < M-1 guarantees the fold never touches the
  // bit being cleared, so a single downward pass fully reduces the value.
  function automatic logic [M-1:0] sq(input logic [M-1:0] x);
    logic [2*M-2:0] t;
    t = '0;
    for (int i = 0; i < M; i++) begin
      t[2*i] = x[i];
    end
    for (int i = 2*M-2; i >= M; i--) begin
      if (t[i]) begin
        t    = t ^ ({{(M-1){1'b0}}, P} << (i - M));
        t[i] = 1'b0;
      end
    end
    return t[M-1:0];
  endfunction

  // Chain SQ_PER squarers so each clock advances the exponent by 2^SQ_PER.
  always_comb begin
    acc_sq = acc;
    for (int k = 0; k < SQ_PER; k++) begin
      acc_sq = sq(acc_sq);
    end
  end

  // Next-state logic: accept in IDLE/DONE, iterate in RUN, complete at cnt==1.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    root_next  = root;
    done_next  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          acc_next   = a_in;
          cnt_next   = CW'(N);
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (cnt > CW'(1)) begin
          acc_next = acc_sq;
          cnt_next = cnt - CW'(1);
        end else begin
          root_next  = acc_sq;
          done_next  = 1'b1;
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      root  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
      root  <= root_next;
      done  <= done_next;
    end
  end

  assign busy = (state == RUN);

endmodule
